// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 serial transmitter.
// A byte FIFO feeds a START/DATA/STOP shifter on a registered tx pin.
module uart_tx_fifo #(
  parameter int unsigned CLKDIV     = 54,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            d,
  input  logic                  strobe,
  output logic                  full,
  output logic                  busy,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  tx
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = $clog2(CLKDIV);
  localparam logic [CW-1:0] TMAX = CW'(CLKDIV - 1);
  localparam logic [DEPTH_LOG2:0] CFULL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic                  rst_sync_q;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_q;
  logic [DEPTH_LOG2-1:0] rd_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  full_q;
  logic                  ovf_q;
  logic                  avail_q;
  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [2:0]            bit_q;
  logic [7:0]            sh_q;
  logic                  tx_q;
  logic                  push;
  logic                  pop;
  logic                  tick;
  logic                  nonempty;

  assign push     = strobe & ~full_q;
  assign tick     = (cnt_q == TMAX);
  assign nonempty = (count_q != '0);
  assign pop      = nonempty &
                    (((state_q == IDLE) & avail_q) |
                     ((state_q == STOP) & tick));

  // Release of reset is retimed to clk; assertion stays asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (DEPTH_LOG2+1)'(1);
    else if (pop && !push) count_d = count_q - (DEPTH_LOG2+1)'(1);
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= d;
  end

  // FIFO pointers, flags and the delayed non-empty seen by IDLE.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      avail_q <= 1'b0;
    end else begin
      wr_q    <= wr_q + DEPTH_LOG2'(push);
      rd_q    <= rd_q + DEPTH_LOG2'(pop);
      count_q <= count_d;
      full_q  <= (count_d == CFULL);
      ovf_q   <= strobe & full_q;
      avail_q <= nonempty;
    end
  end

  // Frame sequencer with registered tx.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          tx_q  <= 1'b1;
          if (pop) begin
            sh_q    <= mem_q[rd_q];
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (tick) begin
            cnt_q <= '0;
            if (pop) begin
              sh_q    <= mem_q[rd_q];
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) | avail_q;
  assign full     = full_q;
  assign overflow = ovf_q;
  assign count    = count_q;

endmodule
